// File: rtl/regfile_scoreboard.sv
// Multi-port register file with per-register pending (scoreboard) bits and write-to-read bypass.
// Latency: reads and rd_busy are combinational (0 cycles); writes, issues and busy_cnt update on the next edge.
// Backpressure: none, every write/issue/flush is accepted on the edge it is presented.
module regfile_scoreboard #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int NREAD    = 2,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1,
    localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we,
    input  logic [AW-1:0]          wa,
    input  logic [WIDTH-1:0]       wd,
    input  logic [NREAD*AW-1:0]    ra,
    output logic [NREAD*WIDTH-1:0] rd,
    input  logic                   iss_v,
    input  logic [AW-1:0]          iss_a,
    input  logic                   flush,
    output logic [NREAD-1:0]       rd_busy,
    output logic [AW:0]            busy_cnt
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    // Addresses past the last register exist only when DEPTH is not a power of two.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return {1'b0, a} < DEPTH_W;
    endfunction

    function automatic logic is_zero(input logic [AW-1:0] a);
        return ZERO_REG && (a == '0);
    endfunction

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;
    logic [AW:0]      cnt_nxt;
    logic             wr_ok;

    assign wr_ok = we && addr_ok(wa) && !is_zero(wa);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < DEPTH; r++) begin
                mem[r] <= '0;
            end
        end else if (wr_ok) begin
            mem[wa] <= wd;
        end
    end

    // Flush beats issue, issue beats the retiring write to the same register.
    always_comb begin
        busy_nxt = busy;
        for (int r = 0; r < DEPTH; r++) begin
            if (flush) begin
                busy_nxt[r] = 1'b0;
            end else if (iss_v && (iss_a == AW'(r)) && !(ZERO_REG && (r == 0))) begin
                busy_nxt[r] = 1'b1;
            end else if (we && (wa == AW'(r))) begin
                busy_nxt[r] = 1'b0;
            end
        end
    end

    always_comb begin
        cnt_nxt = '0;
        for (int r = 0; r < DEPTH; r++) begin
            cnt_nxt = cnt_nxt + {{AW{1'b0}}, busy_nxt[r]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [AW-1:0] a;
        logic          ok;
        logic          hit;

        assign a   = ra[i*AW +: AW];
        // Reset forces the read outputs low even while a write is being presented.
        assign ok  = !rst && addr_ok(a) && !is_zero(a);
        assign hit = BYPASS && we && (wa == a);

        assign rd[i*WIDTH +: WIDTH] = !ok ? '0 : (hit ? wd : mem[a]);
        assign rd_busy[i]           = ok && busy[a] && !hit;
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: default, no-bypass, 3-port DEPTH=8 and DEPTH=6 instances.
module tb_regfile_scoreboard;

    localparam int U0_RD = 0, U0_BZ = 1, U0_CNT = 2;
    localparam int U1_RD = 3, U1_BZ = 4, U1_CNT = 5;
    localparam int U2_RD = 6, U2_BZ = 7, U2_CNT = 8;
    localparam int U3_RD = 9, U3_BZ = 10, U3_CNT = 11;

    logic        clk = 1'b0;
    logic        rst;

    logic        we, iss_v, flush;
    logic [4:0]  wa, iss_a, ra0, ra1;
    logic [31:0] wd;
    logic [63:0] rd0, rd1;
    logic [1:0]  rdb0, rdb1;
    logic [5:0]  cnt0, cnt1;

    logic        we2, iss_v2, flush2;
    logic [2:0]  wa2, iss_a2;
    logic [15:0] wd2;
    logic [8:0]  ra2;
    logic [47:0] rd2, rd3;
    logic [2:0]  rdb2, rdb3;
    logic [3:0]  cnt2, cnt3;

    int          q_sig[$];
    int          q_port[$];
    logic [31:0] q_exp[$];
    string       q_name[$];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    regfile_scoreboard u0 (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .ra({ra1, ra0}), .rd(rd0),
        .iss_v(iss_v), .iss_a(iss_a), .flush(flush), .rd_busy(rdb0), .busy_cnt(cnt0)
    );

    regfile_scoreboard #(.BYPASS(1'b0)) u1 (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .ra({ra1, ra0}), .rd(rd1),
        .iss_v(iss_v), .iss_a(iss_a), .flush(flush), .rd_busy(rdb1), .busy_cnt(cnt1)
    );

    regfile_scoreboard #(.WIDTH(16), .DEPTH(8), .NREAD(3)) u2 (
        .clk(clk), .rst(rst), .we(we2), .wa(wa2), .wd(wd2), .ra(ra2), .rd(rd2),
        .iss_v(iss_v2), .iss_a(iss_a2), .flush(flush2), .rd_busy(rdb2), .busy_cnt(cnt2)
    );

    regfile_scoreboard #(.WIDTH(16), .DEPTH(6), .NREAD(3)) u3 (
        .clk(clk), .rst(rst), .we(we2), .wa(wa2), .wd(wd2), .ra(ra2), .rd(rd3),
        .iss_v(iss_v2), .iss_a(iss_a2), .flush(flush2), .rd_busy(rdb3), .busy_cnt(cnt3)
    );

    function automatic logic [31:0] actual(input int sig, input int port);
        case (sig)
            U0_RD:   return rd0[port*32 +: 32];
            U0_BZ:   return {31'd0, rdb0[port]};
            U0_CNT:  return {26'd0, cnt0};
            U1_RD:   return rd1[port*32 +: 32];
            U1_BZ:   return {31'd0, rdb1[port]};
            U1_CNT:  return {26'd0, cnt1};
            U2_RD:   return {16'd0, rd2[port*16 +: 16]};
            U2_BZ:   return {31'd0, rdb2[port]};
            U2_CNT:  return {28'd0, cnt2};
            U3_RD:   return {16'd0, rd3[port*16 +: 16]};
            U3_BZ:   return {31'd0, rdb3[port]};
            U3_CNT:  return {28'd0, cnt3};
            default: return 32'hxxxx_xxxx;
        endcase
    endfunction

    task automatic chk(input int sig, input int port, input logic [31:0] exp, input string name);
        q_sig.push_back(sig);
        q_port.push_back(port);
        q_exp.push_back(exp);
        q_name.push_back(name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Outputs are compared half a cycle after the inputs change.
    initial begin
        int          s, p;
        logic [31:0] e, a;
        string       n;
        forever begin
            @(negedge clk);
            while (q_sig.size() != 0) begin
                s = q_sig.pop_front();
                p = q_port.pop_front();
                e = q_exp.pop_front();
                n = q_name.pop_front();
                a = actual(s, p);
                n_checks++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL %s: got %h, expected %h", n, a, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before 100000");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        we = 0; wa = 0; wd = 0; ra0 = 0; ra1 = 0; iss_v = 0; iss_a = 0; flush = 0;
        we2 = 0; wa2 = 0; wd2 = 0; ra2 = 0; iss_v2 = 0; iss_a2 = 0; flush2 = 0;

        step();
        we = 1; wa = 5; wd = 32'h55; iss_v = 1; iss_a = 5; ra0 = 5;
        chk(U0_RD, 0, 32'h0, "rst_rd");
        chk(U0_BZ, 0, 32'h0, "rst_busy");
        chk(U0_CNT, 0, 32'h0, "rst_cnt");
        chk(U1_RD, 0, 32'h0, "rst_rd_nobyp");

        step();
        rst = 0; we = 0; iss_v = 0;
        chk(U0_RD, 0, 32'h0, "write_in_rst_ignored");
        chk(U0_CNT, 0, 32'h0, "issue_in_rst_ignored");

        step(); we = 1; wa = 5; wd = 32'd10;
        step(); wa = 2; wd = 32'd15;
        step(); we = 0; ra0 = 2; ra1 = 5;
        chk(U0_RD, 0, 32'd15, "rd_r2");
        chk(U0_RD, 1, 32'd10, "rd_r5");
        chk(U1_RD, 0, 32'd15, "rd_r2_nobyp");
        chk(U1_RD, 1, 32'd10, "rd_r5_nobyp");

        step(); we = 1; wa = 7; wd = 32'hDEADBEEF; ra0 = 7;
        chk(U0_RD, 0, 32'hDEADBEEF, "bypass");
        chk(U1_RD, 0, 32'h0, "no_bypass_old");
        chk(U0_RD, 1, 32'd10, "bypass_other_port");
        step(); we = 0;
        chk(U0_RD, 0, 32'hDEADBEEF, "r7_stored");
        chk(U1_RD, 0, 32'hDEADBEEF, "r7_stored_nobyp");

        step(); we = 1; wa = 0; wd = 32'hFFFFFFFF; iss_v = 1; iss_a = 0; ra0 = 0;
        chk(U0_RD, 0, 32'h0, "r0_write_cycle");
        chk(U0_BZ, 0, 32'h0, "r0_busy_write_cycle");
        chk(U1_RD, 0, 32'h0, "r0_nobyp");
        step(); we = 0; iss_v = 0;
        chk(U0_RD, 0, 32'h0, "r0_after");
        chk(U0_BZ, 0, 32'h0, "r0_busy_after");
        chk(U0_CNT, 0, 32'h0, "r0_cnt");

        step(); iss_v = 1; iss_a = 3;
        step(); iss_a = 4;
        chk(U0_CNT, 0, 32'd1, "cnt_one");
        step(); iss_v = 0; ra0 = 3; ra1 = 4;
        chk(U0_CNT, 0, 32'd2, "cnt_two");
        chk(U0_BZ, 0, 32'd1, "busy_r3");
        chk(U0_BZ, 1, 32'd1, "busy_r4");
        step(); we = 1; wa = 3; wd = 32'h33;
        chk(U0_BZ, 0, 32'd0, "busy_r3_wr_cycle");
        chk(U0_RD, 0, 32'h33, "rd_r3_wr_cycle");
        chk(U1_BZ, 0, 32'd1, "busy_r3_wr_nobyp");
        chk(U0_CNT, 0, 32'd2, "cnt_before_edge");
        step(); we = 0;
        chk(U0_CNT, 0, 32'd1, "cnt_after_wb");
        chk(U0_BZ, 0, 32'd0, "busy_r3_cleared");
        chk(U1_CNT, 0, 32'd1, "cnt_after_wb_nobyp");
        step(); iss_v = 1; iss_a = 4; we = 1; wa = 4; wd = 32'h44;
        chk(U0_BZ, 1, 32'd0, "busy_r4_masked");
        chk(U1_BZ, 1, 32'd1, "busy_r4_nobyp");
        chk(U0_RD, 1, 32'h44, "rd_r4_bypass");
        step(); iss_v = 0; we = 0;
        chk(U0_BZ, 1, 32'd1, "issue_wins");
        chk(U0_RD, 1, 32'h44, "issue_wins_mem");
        chk(U0_CNT, 0, 32'd1, "issue_wins_cnt");

        step(); iss_v = 1; iss_a = 1;
        step(); iss_a = 2;
        step(); iss_a = 9;
        step(); flush = 1; iss_a = 6;
        chk(U0_CNT, 0, 32'd4, "cnt_before_flush");
        step(); flush = 0; iss_v = 0; ra0 = 6;
        chk(U0_CNT, 0, 32'd0, "flush_cnt");
        chk(U0_BZ, 0, 32'd0, "flush_beats_issue");
        chk(U0_BZ, 1, 32'd0, "flush_r4");
        step(); iss_v = 1; iss_a = 6;
        step(); iss_v = 0;
        chk(U0_CNT, 0, 32'd1, "reissue_cnt");
        chk(U0_BZ, 0, 32'd1, "reissue_busy");
        step(); rst = 1; ra1 = 5;
        chk(U0_CNT, 0, 32'd0, "async_rst_cnt");
        chk(U0_BZ, 0, 32'd0, "async_rst_busy");
        chk(U0_RD, 0, 32'h0, "async_rst_rd0");
        chk(U0_RD, 1, 32'h0, "async_rst_rd1");
        chk(U1_CNT, 0, 32'd0, "async_rst_cnt_nobyp");
        step(); rst = 0;
        chk(U0_RD, 1, 32'h0, "mem_cleared_r5");
        chk(U0_CNT, 0, 32'd0, "cnt_after_rst");

        step(); we2 = 1; wa2 = 5; wd2 = 16'h1234;
        step(); we2 = 0; ra2 = {3'd5, 3'd5, 3'd5};
        for (int i = 0; i < 3; i++) begin
            chk(U2_RD, i, 32'h1234, "p3_d8_rd_r5");
            chk(U3_RD, i, 32'h1234, "p3_d6_rd_r5");
        end
        step(); we2 = 1; wa2 = 7; wd2 = 16'hBEEF; iss_v2 = 1; iss_a2 = 7; ra2 = {3'd5, 3'd5, 3'd7};
        chk(U2_RD, 0, 32'hBEEF, "d8_bypass_r7");
        chk(U3_RD, 0, 32'h0, "d6_r7_oob_bypass");
        chk(U3_BZ, 0, 32'h0, "d6_r7_oob_busy_cycle");
        chk(U2_RD, 1, 32'h1234, "d8_p1_r5");
        step(); we2 = 0; iss_v2 = 0;
        chk(U2_RD, 0, 32'hBEEF, "d8_r7_stored");
        chk(U2_CNT, 0, 32'd1, "d8_cnt");
        chk(U2_BZ, 0, 32'd1, "d8_busy_r7");
        chk(U3_RD, 0, 32'h0, "d6_r7_ignored");
        chk(U3_CNT, 0, 32'd0, "d6_issue_ignored");
        chk(U3_BZ, 0, 32'd0, "d6_busy_r7");
        step(); iss_v2 = 1; iss_a2 = 5; ra2 = {3'd5, 3'd5, 3'd5};
        step(); iss_v2 = 0;
        for (int i = 0; i < 3; i++) begin
            chk(U3_BZ, i, 32'd1, "d6_same_reg_busy");
        end
        chk(U3_CNT, 0, 32'd1, "d6_cnt");
        chk(U2_CNT, 0, 32'd2, "d8_cnt_two");

        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (rd2 !== {3{16'h1234}}) begin
            n_fail++;
            $display("FAIL final_rd2: got %h, expected %h", rd2, {3{16'h1234}});
        end
        n_checks++;
        if (rd3 !== {3{16'h1234}}) begin
            n_fail++;
            $display("FAIL final_rd3: got %h, expected %h", rd3, {3{16'h1234}});
        end
        n_checks++;
        if (cnt2 !== 4'd2) begin
            n_fail++;
            $display("FAIL final_cnt2: got %h, expected %h", cnt2, 4'd2);
        end
        n_checks++;
        if (cnt3 !== 4'd1) begin
            n_fail++;
            $display("FAIL final_cnt3: got %h, expected %h", cnt3, 4'd1);
        end
        n_checks++;
        if (rdb3 !== 3'b111) begin
            n_fail++;
            $display("FAIL final_rdb3: got %b, expected %b", rdb3, 3'b111);
        end
        n_checks++;
        if (rdb2 !== 3'b111) begin
            n_fail++;
            $display("FAIL final_rdb2: got %b, expected %b", rdb2, 3'b111);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, meaning the data bits per register.
REQ-002 The module SHALL have parameter DEPTH, default 32, meaning the register count; AW = clog2(DEPTH).
REQ-003 The module SHALL have parameter NREAD, default 2, meaning the number of independent read ports.
REQ-004 The module SHALL have parameter ZERO_REG, default 1: when 1, register 0 reads 0 and ignores writes and issues.
REQ-005 The module SHALL have parameter BYPASS, default 1: when 1, a same-cycle write is forwarded to the reads.
REQ-006 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-007 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-008 The module SHALL have port we, input, 1 bit: write enable.
REQ-009 The module SHALL have port wa, input, AW bits: write address.
REQ-010 The module SHALL have port wd, input, WIDTH bits: write data.
REQ-011 The module SHALL have port ra, input, NREAD*AW bits: read addresses, port i at bits [i*AW +: AW].
REQ-012 The module SHALL have port rd, output, NREAD*WIDTH bits: read data, port i at bits [i*WIDTH +: WIDTH].
REQ-013 The module SHALL have port iss_v, input, 1 bit: issue strobe, marking register iss_a as pending.
REQ-014 The module SHALL have port iss_a, input, AW bits: destination register of the issuing instruction.
REQ-015 The module SHALL have port flush, input, 1 bit: synchronous clear of all pending bits.
REQ-016 The module SHALL have port rd_busy, output, NREAD bits: the pending status of each read address.
REQ-017 The module SHALL have port busy_cnt, output, AW+1 bits: the number of registers currently pending.

Function
REQ-018 On a rising edge with we=1, the module SHALL store wd to mem[wa], except when ZERO_REG=1 and wa=0.
REQ-019 The module SHALL drive each read port combinationally with zero latency.
REQ-020 For read port i, the module SHALL select read data with the following priority.
  - (a) ZERO_REG=1 and ra_i=0 -> 0.
  - (b) BYPASS=1, we=1 and wa=ra_i -> wd.
  - (c) otherwise -> mem[ra_i].
REQ-021 The module SHALL keep one pending bit per register; on a rising edge, the next value of busy[r] SHALL follow this priority.
  - flush=1 -> 0 for every r.
  - iss_v=1 and iss_a=r (and not ZERO_REG with r=0) -> 1.
  - we=1 and wa=r -> 0.
  - else hold.
REQ-022 When an issue and a write target the same register in the same cycle, the module SHALL let the issue win (busy=1); mem SHALL still be written.
REQ-023 When flush and iss_v occur in the same cycle, flush SHALL win and all pending bits SHALL be 0 after the edge.
REQ-024 The module SHALL compute rd_busy[i] = busy[ra_i] AND NOT (BYPASS AND we AND wa=ra_i); rd_busy[i] SHALL be 0 for register 0 when ZERO_REG=1.
REQ-025 The module SHALL register busy_cnt as the population count of the pending bits after each edge, consistent with busy in the same cycle and never exceeding DEPTH.
REQ-026 When several read ports address the same register, the module SHALL give every port identical data and busy.
REQ-027 The module SHALL treat addresses >= DEPTH (DEPTH not a power of 2) as follows: writes and issues are ignored, reads return 0, rd_busy=0.

Reset
REQ-028 While rst=1, regardless of clk, the module SHALL clear every mem entry to 0, every pending bit to 0 and busy_cnt to 0, and every rd output SHALL read 0.
REQ-029 The module SHALL ignore writes, issues and flush while rst=1, and SHALL act normally from the first rising edge after rst falls.
REQ-030 Asserting rst mid-operation with pending bits set SHALL clear them immediately, without waiting for a clock edge.

Verification
REQ-031 The bench SHALL cover the write/read case: rst pulse; we=1 wa=5 wd=10; next cycle wa=2 wd=15; then we=0 ra0=2 ra1=5 -> rd0=15, rd1=10.
REQ-032 The bench SHALL cover bypass: we=1 wa=7 wd=0xDEADBEEF with ra0=7 in the same cycle -> rd0=0xDEADBEEF before the edge; repeated with BYPASS=0 -> old value 0.
REQ-033 The bench SHALL cover the zero register: we=1 wa=0 wd=0xFFFFFFFF, iss_v=1 iss_a=0 -> rd at ra=0 reads 0, rd_busy=0, busy_cnt=0.
REQ-034 The bench SHALL cover the scoreboard: issue r3 and then r4 -> busy_cnt=2; with ra0=3, write r3 -> rd_busy0=0 in the write cycle, busy_cnt=1 after the edge; issue and write r4 together -> r4 stays busy.
REQ-035 The bench SHALL cover flush and reset: with r1, r2 and r9 pending, flush=1 together with iss_v=1 iss_a=6 -> busy_cnt=0; after re-issuing r6, async rst mid-cycle -> busy_cnt=0 and all rd=0 before the next edge.
REQ-036 The bench SHALL cover a parametric configuration: WIDTH=16, DEPTH=8, NREAD=3, with all three ports reading r5 after a write of 0x1234 -> every port reads 0x1234; address 9 cannot be formed (AW=3), and with DEPTH=6 a write to address 7 is ignored and reads 0.
